// File: rtl/paramult_pkg.sv
// Shared constants and helpers for the paramult_regheap_acc block.
//   - Default lane count, data width, fractional bits and heap depth.
//   - Mode encoding for the overwrite/accumulate selection.
//   - sat(): clamps a wide signed value to a w-bit signed range.
package paramult_pkg;

    localparam int unsigned LANES_DEF = 64;
    localparam int unsigned DW_DEF    = 16;
    localparam int unsigned FRAC_DEF  = 8;
    localparam int unsigned DEPTH_DEF = 4;

    localparam logic MODE_OVR = 1'b0;
    localparam logic MODE_ACC = 1'b1;

    // Working width of sat(); must exceed 2*DW+1 for any DW in use.
    localparam int unsigned SAT_W = 128;

    // Clamp x to [-2^(w-1), 2^(w-1)-1]; result stays SAT_W wide, caller slices.
    function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] x,
                                                    input int unsigned             w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = $signed((SAT_W'(1) << (w - 1)) - SAT_W'(1));
        lo = ~hi;
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end else begin
            return x;
        end
    endfunction

endpackage

// File: rtl/paramult_lane.sv
// One lane of the vector-by-scalar multiplier.
//   clk, rst      : clock, asynchronous active-low reset
//   usr_rst       : synchronous clear of the product register
//   cap_i         : capture the product this edge (stage 1)
//   acc_i         : stage-2 beat accumulates onto heap_i instead of overwriting
//   a_i, s_i      : signed lane operand and signed scalar
//   heap_i        : current heap entry value for this lane
//   v_o           : rescaled, saturated result to be written to the heap
//   sat_o         : v_o was clamped
module paramult_lane
    import paramult_pkg::*;
#(
    parameter int unsigned DW   = DW_DEF,
    parameter int unsigned FRAC = FRAC_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          usr_rst,
    input  logic          cap_i,
    input  logic          acc_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] s_i,
    input  logic [DW-1:0] heap_i,
    output logic [DW-1:0] v_o,
    output logic          sat_o
);

    logic signed [2*DW-1:0]  prod_d;
    logic signed [2*DW-1:0]  prod_q;
    logic signed [2*DW-1:0]  shr;
    logic signed [2*DW:0]    sum;
    logic signed [SAT_W-1:0] sum_ext;
    logic signed [SAT_W-1:0] clamp;

    // Both operands are signed, so the 2*DW context sign-extends before multiplying.
    assign prod_d = $signed(a_i) * $signed(s_i);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_q <= '0;
        end else if (usr_rst) begin
            prod_q <= '0;
        end else if (cap_i) begin
            prod_q <= prod_d;
        end
    end

    always_comb begin
        shr     = prod_q >>> FRAC;
        // Sign-extend both addends to 2*DW+1 bits so the sum cannot overflow.
        sum     = {shr[2*DW-1], shr}
                + (acc_i ? {{(DW+1){heap_i[DW-1]}}, heap_i} : {(2*DW+1){1'b0}});
        sum_ext = {{(SAT_W-2*DW-1){sum[2*DW]}}, sum};
        clamp   = sat(sum_ext, DW);
        v_o     = clamp[DW-1:0];
        sat_o   = (clamp != sum_ext);
    end

endmodule

// File: rtl/paramult_regheap_acc.sv
// Vector-by-scalar fixed-point multiplier feeding a multi-entry result register heap.
// Each valid beat multiplies LANES signed lanes by one signed scalar, rescales by FRAC,
// saturates, and overwrites or accumulates into the heap entry at wr_ptr.
//   clk, rst       : clock, asynchronous active-low reset
//   usr_rst        : synchronous clear of heap, pointer, pipeline and flags
//   data_v         : beat valid
//   in_mode        : 0 overwrite, 1 accumulate (sampled with data_v)
//   in_veca_data   : lane i at [i*DW +: DW]
//   in_sig_data    : scalar
//   reg_data_w     : value last written to the heap (held between beats)
//   reg_data_v_w   : one-cycle pulse per completed beat
//   reg_idx_w      : heap index written by the beat
//   heap_wrap_w    : pulse with the beat that writes index DEPTH-1
//   sat_flag_w     : sticky saturation flag
module paramult_regheap_acc
    import paramult_pkg::*;
#(
    parameter int unsigned LANES = LANES_DEF,
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned FRAC  = FRAC_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    localparam int unsigned IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                usr_rst,
    input  logic                data_v,
    input  logic                in_mode,
    input  logic [LANES*DW-1:0] in_veca_data,
    input  logic [DW-1:0]       in_sig_data,
    output logic [LANES*DW-1:0] reg_data_w,
    output logic                reg_data_v_w,
    output logic [IW-1:0]       reg_idx_w,
    output logic                heap_wrap_w,
    output logic                sat_flag_w
);

    logic [LANES*DW-1:0] heap_q [DEPTH];
    logic [IW-1:0]       wr_ptr_q;
    logic [IW-1:0]       wr_ptr_d;
    logic                last_entry;
    logic                valid1_q;
    logic                mode_q;
    logic                cap;

    logic [LANES*DW-1:0] cur_entry;
    logic [LANES*DW-1:0] lane_v;
    logic [LANES-1:0]    lane_sat;

    logic [LANES*DW-1:0] data_q;
    logic                dv_q;
    logic [IW-1:0]       idx_q;
    logic                wrap_q;
    logic                sat_q;
    logic                sat_d;

    // usr_rst drops a coincident beat as well as anything in flight.
    assign cap = data_v & ~usr_rst;

    always_comb begin
        cur_entry  = heap_q[wr_ptr_q];
        last_entry = (wr_ptr_q == IW'(DEPTH - 1));
        wr_ptr_d   = last_entry ? '0 : wr_ptr_q + IW'(1);
        sat_d      = sat_q | (valid1_q & (|lane_sat));
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        paramult_lane #(
            .DW   (DW),
            .FRAC (FRAC)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .usr_rst (usr_rst),
            .cap_i   (cap),
            .acc_i   (mode_q == MODE_ACC),
            .a_i     (in_veca_data[g*DW +: DW]),
            .s_i     (in_sig_data),
            .heap_i  (cur_entry[g*DW +: DW]),
            .v_o     (lane_v[g*DW +: DW]),
            .sat_o   (lane_sat[g])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                heap_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            valid1_q <= 1'b0;
            mode_q   <= MODE_OVR;
            data_q   <= '0;
            dv_q     <= 1'b0;
            idx_q    <= '0;
            wrap_q   <= 1'b0;
            sat_q    <= 1'b0;
        end else if (usr_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                heap_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            valid1_q <= 1'b0;
            mode_q   <= MODE_OVR;
            data_q   <= '0;
            dv_q     <= 1'b0;
            idx_q    <= '0;
            wrap_q   <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            valid1_q <= data_v;
            if (data_v) begin
                mode_q <= in_mode;
            end
            dv_q   <= valid1_q;
            wrap_q <= valid1_q & last_entry;
            sat_q  <= sat_d;
            if (valid1_q) begin
                heap_q[wr_ptr_q] <= lane_v;
                data_q           <= lane_v;
                idx_q            <= wr_ptr_q;
                wr_ptr_q         <= wr_ptr_d;
            end
        end
    end

    assign reg_data_w   = data_q;
    assign reg_data_v_w = dv_q;
    assign reg_idx_w    = idx_q;
    assign heap_wrap_w  = wrap_q;
    assign sat_flag_w   = sat_q;

endmodule

// File: tb/tb_paramult_regheap_acc.sv
// Directed bench: a DEPTH=4 instance and a DEPTH=1 instance share all inputs except
// their beat-valid strobes. Inputs change on the falling edge; outputs are sampled
// on the falling edge, so a beat driven at falling edge n is visible at edge n+2.
module tb_paramult_regheap_acc;

    localparam int unsigned L  = 64;
    localparam int unsigned W  = 16;
    localparam int unsigned VW = L * W;

    logic          clk;
    logic          rst;
    logic          usr_rst;
    logic          dv4;
    logic          dv1;
    logic          in_mode;
    logic [VW-1:0] a;
    logic [W-1:0]  s;

    logic [VW-1:0] o4_data;
    logic          o4_v;
    logic [1:0]    o4_idx;
    logic          o4_wrap;
    logic          o4_sat;
    logic [VW-1:0] o1_data;
    logic          o1_v;
    logic [0:0]    o1_idx;
    logic          o1_wrap;
    logic          o1_sat;

    int checks = 0;
    int errors = 0;

    paramult_regheap_acc #(
        .LANES (L),
        .DW    (W),
        .FRAC  (8),
        .DEPTH (4)
    ) u_dut4 (
        .clk          (clk),
        .rst          (rst),
        .usr_rst      (usr_rst),
        .data_v       (dv4),
        .in_mode      (in_mode),
        .in_veca_data (a),
        .in_sig_data  (s),
        .reg_data_w   (o4_data),
        .reg_data_v_w (o4_v),
        .reg_idx_w    (o4_idx),
        .heap_wrap_w  (o4_wrap),
        .sat_flag_w   (o4_sat)
    );

    paramult_regheap_acc #(
        .LANES (L),
        .DW    (W),
        .FRAC  (8),
        .DEPTH (1)
    ) u_dut1 (
        .clk          (clk),
        .rst          (rst),
        .usr_rst      (usr_rst),
        .data_v       (dv1),
        .in_mode      (in_mode),
        .in_veca_data (a),
        .in_sig_data  (s),
        .reg_data_w   (o1_data),
        .reg_data_v_w (o1_v),
        .reg_idx_w    (o1_idx),
        .heap_wrap_w  (o1_wrap),
        .sat_flag_w   (o1_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [VW-1:0] fill(input logic [W-1:0] x);
        logic [VW-1:0] r;
        for (int i = 0; i < int'(L); i++) r[i*W +: W] = x;
        return r;
    endfunction

    // Lane i holds (i-32)*k as a 16-bit raw value.
    function automatic logic [VW-1:0] ramp(input int k);
        logic [VW-1:0] r;
        for (int i = 0; i < int'(L); i++) r[i*W +: W] = W'((i - 32) * k);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        int bad;
        bad = 0;
        for (int i = int'(L) - 1; i >= 0; i--) begin
            if (obs[i*W +: W] !== exp[i*W +: W]) bad = i;
        end
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: lane %0d observed %h expected %h", tag, bad,
                   obs[bad*W +: W], exp[bad*W +: W]);
        end
    endtask

    task automatic chk_out(input logic sel1, input string tag, input logic ev,
                           input logic [VW-1:0] evec, input int eidx,
                           input logic ewrap, input logic esat);
        if (sel1) begin
            chk({tag, "_v"}, 32'(o1_v), 32'(ev));
            chk_vec({tag, "_data"}, o1_data, evec);
            chk({tag, "_idx"}, 32'(o1_idx), 32'(eidx));
            chk({tag, "_wrap"}, 32'(o1_wrap), 32'(ewrap));
            chk({tag, "_sat"}, 32'(o1_sat), 32'(esat));
        end else begin
            chk({tag, "_v"}, 32'(o4_v), 32'(ev));
            chk_vec({tag, "_data"}, o4_data, evec);
            chk({tag, "_idx"}, 32'(o4_idx), 32'(eidx));
            chk({tag, "_wrap"}, 32'(o4_wrap), 32'(ewrap));
            chk({tag, "_sat"}, 32'(o4_sat), 32'(esat));
        end
    endtask

    task automatic drive(input logic v4, input logic v1, input logic m,
                         input logic [VW-1:0] av, input logic [W-1:0] sv);
        dv4     = v4;
        dv1     = v1;
        in_mode = m;
        a       = av;
        s       = sv;
    endtask

    // One isolated beat on the selected instance, checked two edges later.
    task automatic single(input logic sel1, input string tag, input logic m,
                          input logic [VW-1:0] av, input logic [W-1:0] sv,
                          input logic [VW-1:0] evec, input int eidx,
                          input logic ewrap, input logic esat);
        @(negedge clk);
        drive(!sel1, sel1, m, av, sv);
        @(negedge clk);
        drive(1'b0, 1'b0, m, av, sv);
        @(negedge clk);
        chk_out(sel1, tag, 1'b1, evec, eidx, ewrap, esat);
    endtask

    initial begin
        rst     = 1'b0;
        usr_rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0);

        // Reset state
        repeat (2) @(negedge clk);
        chk_out(1'b0, "rst4", 1'b0, '0, 0, 1'b0, 1'b0);
        chk_out(1'b1, "rst1", 1'b0, '0, 0, 1'b0, 1'b0);
        rst = 1'b1;

        // Six back-to-back overwrite beats of 1.0 x 1.0 on DEPTH=4
        for (int t = 0; t < 9; t++) begin
            @(negedge clk);
            if (t >= 2 && t < 8) begin
                chk_out(1'b0, $sformatf("ovr6_b%0d", t - 2), 1'b1, fill(16'h0100),
                        (t - 2) % 4, ((t - 2) % 4) == 3, 1'b0);
            end else if (t == 8) begin
                chk_out(1'b0, "ovr6_hold", 1'b0, fill(16'h0100), 1, 1'b0, 1'b0);
            end
            drive(t < 6, 1'b0, 1'b0, fill(16'h0100), 16'h0100);
        end

        // Per-lane distinct values: (i-32)*1.0 x 1.5 at index 2
        single(1'b0, "ramp", 1'b0, ramp(256), 16'h0180, ramp(384), 2, 1'b0, 1'b0);

        // Positive saturation at index 3 (wrap), then sticky flag on a clean beat
        single(1'b0, "satp", 1'b0, fill(16'h7F00), 16'h0200, fill(16'h7FFF), 3, 1'b1, 1'b1);
        single(1'b0, "sticky", 1'b0, fill(16'h0100), 16'h0100, fill(16'h0100), 0, 1'b0, 1'b1);

        // DEPTH=1: three consecutive accumulate beats
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            if (t >= 2 && t < 5) begin
                chk_out(1'b1, $sformatf("acc3_b%0d", t - 2), 1'b1,
                        fill(W'(16'h0100 * (t - 1))), 0, 1'b1, 1'b0);
            end else if (t == 5) begin
                chk({"acc3_idle_v"}, 32'(o1_v), 32'd0);
            end
            drive(1'b0, t < 3, 1'b1, fill(16'h0100), 16'h0100);
        end

        // DEPTH=1: negative values, accumulate, negative clamp, truncation toward -inf
        single(1'b1, "neg_ovr", 1'b0, fill(16'hFF00), 16'h0180, fill(16'hFE80), 0, 1'b1, 1'b0);
        single(1'b1, "neg_acc", 1'b1, fill(16'hFF00), 16'h0180, fill(16'hFD00), 0, 1'b1, 1'b0);
        single(1'b1, "satn1", 1'b1, fill(16'h8000), 16'h0100, fill(16'h8000), 0, 1'b1, 1'b1);
        single(1'b1, "satn2", 1'b1, fill(16'h8000), 16'h0100, fill(16'h8000), 0, 1'b1, 1'b1);
        single(1'b1, "trunc", 1'b0, fill(16'hFFFF), 16'h0080, fill(16'hFFFF), 0, 1'b1, 1'b1);

        // usr_rst: in-flight beat and coincident beat are dropped, flags and heap clear
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, fill(16'h0100), 16'h0100);
        @(negedge clk);
        usr_rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, fill(16'h0300), 16'h0100);
        @(negedge clk);
        usr_rst = 1'b0;
        chk_out(1'b0, "urst4", 1'b0, '0, 0, 1'b0, 1'b0);
        chk({"urst1_sat"}, 32'(o1_sat), 32'd0);
        drive(1'b1, 1'b0, 1'b1, fill(16'h0200), 16'h0100);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        chk({"urst_drop_v"}, 32'(o4_v), 32'd0);
        @(negedge clk);
        chk_out(1'b0, "urst_next", 1'b1, fill(16'h0200), 0, 1'b0, 1'b0);

        // Asynchronous rst between edges mid-stream
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, fill(16'h7F00), 16'h0200);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, fill(16'h0100), 16'h0100);
        @(negedge clk);
        chk({"pre_arst_sat"}, 32'(o4_sat), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk_out(1'b0, "arst4", 1'b0, '0, 0, 1'b0, 1'b0);
        chk_out(1'b1, "arst1", 1'b0, '0, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b1, fill(16'h0100), 16'h0100);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        chk({"arst_drop_v"}, 32'(o4_v), 32'd0);
        @(negedge clk);
        chk_out(1'b0, "arst_next", 1'b1, fill(16'h0100), 0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/paramult_regheap_acc.md
# paramult_regheap_acc

Parametrised vector-by-scalar fixed-point multiplier with a multi-entry result register heap and per-beat overwrite/accumulate mode. Each valid beat multiplies LANES signed lanes by one signed scalar, rescales and saturates, and writes the result into the next heap entry. In accumulate mode the result is added to that entry. The block is the next generation of the single-entry parallel-multiply register heap, sitting between the vector operand stream and the dense-layer datapath.

## Interface
- LANES, 64, number of parallel lanes
- DW, 16, lane and scalar width (signed two's complement)
- FRAC, 8, fractional bits (Q(DW-FRAC).FRAC; 0x0100 = 1.0 at defaults)
- DEPTH, 4, heap entries (≥1, need not be a power of 2)
- IW, $clog2(DEPTH) (min 1), index width (derived, not overridden)

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- usr_rst  in  1  synchronous clear of heap, pointer, pipeline and flags
- data_v  in  1  beat valid
- in_mode  in  1  0 = overwrite, 1 = accumulate; sampled with data_v
- in_veca_data  in  LANES*DW  lane i at bits [i*DW +: DW]
- in_sig_data  in  DW  scalar
- reg_data_w  out  LANES*DW  value just written to the heap
- reg_data_v_w  out  1  one-cycle pulse per completed beat
- reg_idx_w  out  IW  heap index written by this beat
- heap_wrap_w  out  1  pulse with the beat that writes index DEPTH-1
- sat_flag_w  out  1  sticky: any lane saturated since last reset/usr_rst

## Operation
- Stage 1, capture edge: when data_v=1, register the per-lane products a[i]*s (2*DW signed), in_mode, and valid.
- Stage 2:
  - r[i] = product >>> FRAC (arithmetic shift, truncation toward −inf).
  - Overwrite: v = sat(r[i]). Accumulate: v = sat(r[i] + heap[wr_ptr][i]), with the sum computed at 2*DW+1 bits.
  - sat() clamps to [−2^(DW−1), 2^(DW−1)−1].
  - Write v to heap[wr_ptr]. Drive reg_data_w = v, reg_idx_w = wr_ptr, reg_data_v_w = 1.
  - wr_ptr advances, returning to 0 after DEPTH−1.
- sat_flag_w sets when any lane clamps on a valid stage-2 beat. It clears only on rst or usr_rst.
- Back-to-back beats, including DEPTH=1 accumulate, need no stall. Stage 2 reads the heap entry as updated by the previous edge.
- No backpressure. Every valid beat is consumed.
- No state machine beyond the 2-stage valid pipeline and wr_ptr.

## Timing
- Latency: data_v high before edge k → reg_data_v_w high during the cycle after edge k+1 (2 cycles). Throughput is 1 beat per cycle.
- reg_data_w holds its last value when reg_data_v_w=0.
- rst low, asynchronous: all heap entries 0, wr_ptr 0, pipeline valids 0. All outputs 0: reg_data_w=0, reg_data_v_w=0, reg_idx_w=0, heap_wrap_w=0, sat_flag_w=0.
- usr_rst=1 at an edge gives the same result as rst at that edge. It takes precedence over data_v in the same cycle, and that beat and any in-flight beats are dropped (no reg_data_v_w pulse).
- A data_v beat in the cycle after usr_rst deasserts is accepted normally, starting at index 0.
- Wrap: heap_wrap_w and reg_data_v_w are coincident. The next beat writes index 0.
- in_mode may change every beat. Each beat uses its own sampled mode.

## Structure
- Package paramult_pkg: default LANES/DW/FRAC/DEPTH constants, mode encoding (MODE_OVR=0, MODE_ACC=1), and sat function.
- Sub-module paramult_lane: one lane's multiply, stage-1 register, shift, add and saturate. It outputs v and a sat bit. Instantiate LANES times via generate.
- The top level owns the heap array, wr_ptr, valid pipeline, flag OR-reduction and output registers.

## Test plan
- Reset, then 6 overwrite beats, all lanes 0x0100, scalar 0x0100 (DEPTH=4):
  - Each beat outputs every lane 0x0100, 2 cycles after data_v.
  - reg_idx_w = 0,1,2,3,0,1.
  - heap_wrap_w pulses only with idx 3.
- DEPTH=1, 3 consecutive accumulate beats of 0x0100×0x0100 → outputs 0x0100, 0x0200, 0x0300 on consecutive cycles.
- Lanes 0x7F00 × scalar 0x0200, overwrite → all lanes 0x7FFF, sat_flag_w=1. It stays 1 after a following non-saturating beat.
- Lane 0xFF00 (−1.0) × scalar 0x0180 (1.5) → 0xFE80. Then accumulate with the same operands on the same index (DEPTH=1) → 0xFD00. Then 0x8000×0x0100 accumulated repeatedly clamps at 0x8000.
- usr_rst mid-stream:
  - A beat coincident with usr_rst and one in flight produce no output.
  - sat_flag_w clears.
  - The next beat outputs reg_idx_w=0, and in accumulate mode the sum starts from 0.
- rst asserted asynchronously between edges mid-stream → all outputs 0 immediately. After release, the first beat writes idx 0.
